order_book_v1: RTL and testbench
================================

Name: order_book_v1

Overview:
- Single-sided (bid) limit order book holding the 10 best price levels, kept sorted with the highest price first.
- Accepts one price/quantity update per clock on an AXI-Stream-style slave input.
- Presents the full sorted book as registered parallel outputs for downstream strategy logic in the market-data acceleration path.

Parameters:
- DEPTH, 10, number of bid levels held. Port widths below assume 10.
- PW, 32, price width in bits.
- QW, 32, quantity width in bits.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-low reset.
- slave_tdata  input  64  update word: [63:32] price (unsigned), [31:0] quantity (unsigned).
- slave_tvalid  input  1  slave_tdata is valid this cycle. No backpressure; the block always accepts.
- bidprices_out  output  [9:0][31:0]  level prices. Index 0 is the best (highest) level.
- bidquantities_out  output  [9:0][31:0]  level quantities, index-aligned with bidprices_out.

Behaviour:
- Reset (rst=0, asynchronous): every price and quantity register clears to 0 immediately, independent of clk. Reset held low blocks all updates. An update arriving during reset is lost.
- An empty level has price 0 and quantity 0. Valid levels are always contiguous from index 0; empties sit only at the tail.
- An update is accepted on a rising clk edge where rst=1 and slave_tvalid=1. slave_tdata is ignored when slave_tvalid=0.
- Latency: the outputs reflect an accepted update on the edge that accepts it, i.e. visible one cycle after presentation. Back-to-back updates on consecutive cycles must all be applied in order.
- Decode: P = slave_tdata[63:32], Q = slave_tdata[31:0].
- P = 0: the update is ignored.
- Match (P equals a valid level's price):
  - Q != 0: that level's quantity becomes old + Q, saturating at 0xFFFFFFFF. Ordering is unchanged.
  - Q = 0: the level is deleted. Levels below it shift up one index and the last index becomes empty.
- No match, Q = 0: ignored.
- No match, Q != 0: insert at index k, the first index whose price is < P or which is empty.
  - Levels k..8 shift down one index. The level previously at index 9 is discarded.
  - If k would be 10 (book full and P below every level): ignored, book unchanged.
- Price compare is unsigned.
- Insertion position is computed combinationally from the current registers: a per-level greater-than compare vector plus a per-level equality vector, then a single-cycle shift. No multi-cycle state machine.
- Outputs are driven directly from the state registers; there is no combinational path from inputs to outputs.

Test Plan:
- Reset: drive rst=0 mid-operation with a populated book -> all 20 output words read 0 immediately, before the next clk edge. Release rst=1 -> book remains empty.
- Sorted insert: send {12304,27}, {12702,71}, {12000,15} on consecutive cycles with tvalid=1 -> prices [12702,12304,12000,0,...], quantities [71,27,15,0,...].
- Aggregate/delete: from the previous state, send {12304,5} -> qty[1]=32. Then send {12702,0} -> prices [12304,12000,0...], quantities [32,15,0...].
- Overflow: insert prices 100..1000 step 100 (10 levels), then {1050,1} -> index0=1050, old 100 discarded. Then {50,9} -> ignored.
- Ignore rules: tvalid=0 with {500,5} -> no change. {0,7} -> no change. {777,0} with 777 absent -> no change.
- Saturation: {200,0xFFFFFFF0} then {200,0x20} -> quantity 0xFFFFFFFF.

Source files
------------

// File: rtl/order_book_v1.sv
// Bid-side limit order book: keeps the DEPTH best price levels sorted highest-first.
// Latency: an accepted update is visible on the outputs one cycle after presentation.
// Backpressure: none; every valid update is consumed on the edge it is presented.
module order_book_v1 #(
    parameter int DEPTH = 10,
    parameter int PW    = 32,
    parameter int QW    = 32
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [PW+QW-1:0]             slave_tdata,
    input  logic                         slave_tvalid,
    output logic [DEPTH-1:0][PW-1:0]     bidprices_out,
    output logic [DEPTH-1:0][QW-1:0]     bidquantities_out
);

    logic [PW-1:0]               upd_price;
    logic [QW-1:0]               upd_qty;

    logic [DEPTH-1:0][PW-1:0]    price_q;
    logic [DEPTH-1:0][PW-1:0]    price_d;
    logic [DEPTH-1:0][QW-1:0]    qty_q;
    logic [DEPTH-1:0][QW-1:0]    qty_d;

    // Neighbour views of the book: *_up[i] is level i+1, *_dn[i] is level i-1,
    // with zero (an empty level) shifted in at the ends.
    logic [DEPTH-1:0][PW-1:0]    price_up;
    logic [DEPTH-1:0][PW-1:0]    price_dn;
    logic [DEPTH-1:0][QW-1:0]    qty_up;
    logic [DEPTH-1:0][QW-1:0]    qty_dn;

    logic [DEPTH-1:0]            lvl_vld;
    logic [DEPTH-1:0]            eq_vec;
    logic [DEPTH-1:0]            gt_vec;
    logic [DEPTH-1:0]            gt_prev;
    logic                        hit;
    logic                        past_hit;
    logic [QW:0]                 qty_sum;

    assign upd_price = slave_tdata[PW+QW-1:QW];
    assign upd_qty   = slave_tdata[QW-1:0];

    assign price_up  = {PW'(0), price_q[DEPTH-1:1]};
    assign qty_up    = {QW'(0), qty_q[DEPTH-1:1]};
    assign price_dn  = {price_q[DEPTH-2:0], PW'(0)};
    assign qty_dn    = {qty_q[DEPTH-2:0], QW'(0)};

    // Per-level compare vectors; empty levels (price 0) lose every greater-than test,
    // so the greater-than vector is a thermometer whose first set bit is the insert slot.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            lvl_vld[i] = (price_q[i] != '0);
            eq_vec[i]  = lvl_vld[i] && (price_q[i] == upd_price);
            gt_vec[i]  = (upd_price > price_q[i]);
        end
        gt_prev = {gt_vec[DEPTH-2:0], 1'b0};
        hit     = |eq_vec;
    end

    // Single-cycle book update: aggregate, delete-and-close-gap, or insert-and-shift.
    always_comb begin
        price_d  = price_q;
        qty_d    = qty_q;
        past_hit = 1'b0;
        qty_sum  = '0;
        if (slave_tvalid && (upd_price != '0)) begin
            if (hit) begin
                if (upd_qty != '0) begin
                    for (int i = 0; i < DEPTH; i++) begin
                        if (eq_vec[i]) begin
                            qty_sum  = {1'b0, qty_q[i]} + {1'b0, upd_qty};
                            qty_d[i] = qty_sum[QW] ? {QW{1'b1}} : qty_sum[QW-1:0];
                        end
                    end
                end else begin
                    for (int i = 0; i < DEPTH; i++) begin
                        past_hit = past_hit | eq_vec[i];
                        if (past_hit) begin
                            price_d[i] = price_up[i];
                            qty_d[i]   = qty_up[i];
                        end
                    end
                end
            end else if (upd_qty != '0) begin
                // A fully-populated book with a price below every level has no set
                // bit in gt_vec, so nothing changes.
                for (int i = 0; i < DEPTH; i++) begin
                    if (gt_vec[i] && !gt_prev[i]) begin
                        price_d[i] = upd_price;
                        qty_d[i]   = upd_qty;
                    end else if (gt_vec[i]) begin
                        price_d[i] = price_dn[i];
                        qty_d[i]   = qty_dn[i];
                    end
                end
            end
        end
    end

    // Book registers; reset empties every level immediately.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            price_q <= '0;
            qty_q   <= '0;
        end else begin
            price_q <= price_d;
            qty_q   <= qty_d;
        end
    end

    assign bidprices_out     = price_q;
    assign bidquantities_out = qty_q;

endmodule

// File: tb/tb_order_book_v1.sv
// Testbench for order_book_v1: directed scenarios followed by random updates.
// Expected book comes from a queue-based model of the order-book rules.
// Inputs are driven on the falling edge; outputs are sampled on the falling edge.
module tb_order_book_v1;

    localparam int DEPTH = 10;

    logic                   clk = 1'b0;
    logic                   rst;
    logic [63:0]            slave_tdata;
    logic                   slave_tvalid;
    logic [9:0][31:0]       bidprices_out;
    logic [9:0][31:0]       bidquantities_out;

    int tests = 0;
    int fails = 0;

    logic [31:0] mp[$];
    logic [31:0] mq[$];

    always #5 clk = ~clk;

    order_book_v1 dut (
        .clk               (clk),
        .rst               (rst),
        .slave_tdata       (slave_tdata),
        .slave_tvalid      (slave_tvalid),
        .bidprices_out     (bidprices_out),
        .bidquantities_out (bidquantities_out)
    );

    // Reference: a sorted list of (price, qty) levels, at most DEPTH long.
    function automatic void model_apply(input logic v, input logic [31:0] p, input logic [31:0] q);
        int idx;
        int k;
        logic [32:0] s;
        idx = -1;
        if (!v || p == 0) return;
        foreach (mp[i]) if (mp[i] == p) idx = i;
        if (idx >= 0) begin
            if (q != 0) begin
                s = {1'b0, mq[idx]} + {1'b0, q};
                mq[idx] = s[32] ? 32'hFFFF_FFFF : s[31:0];
            end else begin
                mp.delete(idx);
                mq.delete(idx);
            end
        end else if (q != 0) begin
            k = 0;
            while (k < mp.size() && mp[k] >= p) k++;
            if (k < DEPTH) begin
                mp.insert(k, p);
                mq.insert(k, q);
                if (mp.size() > DEPTH) begin
                    void'(mp.pop_back());
                    void'(mq.pop_back());
                end
            end
        end
    endfunction

    task automatic check_book(input string tag);
        logic [9:0][31:0] ep;
        logic [9:0][31:0] eq;
        for (int i = 0; i < DEPTH; i++) begin
            ep[i] = (i < mp.size()) ? mp[i] : 32'd0;
            eq[i] = (i < mq.size()) ? mq[i] : 32'd0;
        end
        tests++;
        assert (bidprices_out === ep) else begin
            fails++;
            $error("FAIL %s prices observed=%h expected=%h", tag, bidprices_out, ep);
        end
        tests++;
        assert (bidquantities_out === eq) else begin
            fails++;
            $error("FAIL %s quantities observed=%h expected=%h", tag, bidquantities_out, eq);
        end
    endtask

    task automatic check_word(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Present one update on the next falling edge; it is accepted on the following rising edge.
    task automatic send(input logic v, input logic [31:0] p, input logic [31:0] q);
        @(negedge clk);
        slave_tvalid = v;
        slave_tdata  = {p, q};
        model_apply(v, p, q);
    endtask

    // Let the last update land, stop driving, and compare the whole book.
    task automatic idle_check(input string tag);
        @(negedge clk);
        slave_tvalid = 1'b0;
        check_book(tag);
    endtask

    initial begin
        logic [31:0] rp;
        logic [31:0] rq;
        logic        rv;
        string       tag;

        rst          = 1'b0;
        slave_tvalid = 1'b0;
        slave_tdata  = '0;
        #1;
        check_book("reset_state");
        @(negedge clk);
        rst = 1'b1;
        idle_check("after_reset_release");

        // Sorted insert, back to back.
        send(1'b1, 32'd12304, 32'd27);
        send(1'b1, 32'd12702, 32'd71);
        send(1'b1, 32'd12000, 32'd15);
        idle_check("sorted_insert");
        check_word("insert_p0", bidprices_out[0], 32'd12702);
        check_word("insert_p2", bidprices_out[2], 32'd12000);
        check_word("insert_q1", bidquantities_out[1], 32'd27);

        // Aggregate then delete the best level.
        send(1'b1, 32'd12304, 32'd5);
        idle_check("aggregate");
        check_word("aggregate_q1", bidquantities_out[1], 32'd32);
        send(1'b1, 32'd12702, 32'd0);
        idle_check("delete_top");
        check_word("delete_p0", bidprices_out[0], 32'd12304);
        check_word("delete_p2", bidprices_out[2], 32'd0);

        // Asynchronous reset with a populated book, between clock edges.
        @(negedge clk);
        #2;
        rst = 1'b0;
        mp.delete();
        mq.delete();
        #1;
        check_book("async_reset_immediate");
        // An update presented while reset is held is lost.
        @(negedge clk);
        slave_tvalid = 1'b1;
        slave_tdata  = {32'd500, 32'd5};
        @(negedge clk);
        slave_tvalid = 1'b0;
        check_book("update_during_reset");
        rst = 1'b1;
        idle_check("reset_released_empty");

        // Fill the book, then overflow from the top and try below the bottom.
        for (int i = 1; i <= 10; i++) send(1'b1, 32'(i * 100), 32'(i));
        idle_check("fill_ten");
        send(1'b1, 32'd1050, 32'd1);
        idle_check("overflow_insert");
        check_word("overflow_p0", bidprices_out[0], 32'd1050);
        check_word("overflow_p9", bidprices_out[9], 32'd200);
        send(1'b1, 32'd50, 32'd9);
        idle_check("below_full_book");

        // Ignore rules.
        send(1'b0, 32'd500, 32'd5);
        idle_check("tvalid_low");
        send(1'b1, 32'd0, 32'd7);
        idle_check("price_zero");
        send(1'b1, 32'd777, 32'd0);
        idle_check("absent_delete");

        // Saturating aggregation.
        send(1'b1, 32'd200, 32'hFFFF_FFF0);
        send(1'b1, 32'd200, 32'h20);
        idle_check("saturation");
        check_word("saturation_q9", bidquantities_out[9], 32'hFFFF_FFFF);

        // Random updates from a small price set so matches and deletes are frequent.
        for (int n = 0; n < 400; n++) begin
            rv = ($urandom_range(0, 7) != 0);
            rp = 32'($urandom_range(0, 24) * 25);
            case ($urandom_range(0, 7))
                0, 1:    rq = 32'd0;
                2:       rq = 32'hFFFF_FF00 + 32'($urandom_range(0, 255));
                default: rq = 32'($urandom_range(1, 1000));
            endcase
            send(rv, rp, rq);
            if ((n % 3) == 2) begin
                tag = $sformatf("random_%0d", n);
                idle_check(tag);
            end
        end
        idle_check("random_final");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
